hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central pipeline controller for the five-stage RISC-V core. It produces the stall, flush and enable signals for the IF, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects. It also runs a data-memory wait state machine with a timeout watchdog and keeps a stall-cycle counter. It sits beside the datapath and drives the enable and flush ports of every pipeline register.

## Interface

- MEM_TIMEOUT, 255: maximum number of consecutive wait cycles on a data-memory access before an error is declared; ≥1.
- CNT_W, 32: width of the stall counter.

- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  reset, asynchronous, active-low.
- rs1d_i, rs2d_i  in  5 each  source registers in ID.
- rs1e_i, rs2e_i, rde_i  in  5 each  source and destination registers in EX.
- resultsrce_i  in  2  EX result source; 2'b01 means a load.
- pcsrce_i  in  1  taken branch or jump resolved in EX.
- rdm_i, regwritem_i  in  5 / 1  MEM destination register and write enable.
- rdw_i, regwritew_i  in  5 / 1  WB destination register and write enable.
- memreqm_i  in  1  MEM stage performs a load or store.
- memreadym_i  in  1  data memory completes the access this cycle.
- stallf_o, stalld_o, stalle_o  out  1  hold PC, IF/ID and ID/EX respectively.
- flushd_o, flushe_o, flushw_o  out  1  clear IF/ID, ID/EX and MEM/WB respectively.
- enablem_o  out  1  EX/MEM load enable.
- forwardae_o, forwardbe_o  out  2  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- memerr_o  out  1  sticky memory timeout flag.
- stallcnt_o  out  CNT_W  count of cycles with stallf_o=1.

## Operation

- **FSM states:**
  - RUN. In RUN, when memreqm_i=1 and memreadym_i=0, the controller moves to WAIT.
  - WAIT. In WAIT, memreadym_i=1 returns the controller to RUN. When waitcnt reaches MEM_TIMEOUT with memreadym_i=0, the controller moves to ERR.
  - ERR. ERR is left only by reset.
- **waitcnt:**
  - Reset value 0.
  - Loads 1 on the RUN→WAIT transition.
  - Increments each cycle in WAIT.
  - Clears on the WAIT→RUN transition.
  - Width is $clog2(MEM_TIMEOUT+1).
- **memstall:**
  - Defined as memreqm_i & ~memreadym_i, combinational, in RUN or WAIT.
  - While memstall=1:
    - stallf_o = stalld_o = stalle_o = 1.
    - enablem_o = 0.
    - flushw_o = 1, so a bubble enters WB.
    - flushd_o = flushe_o = 0.
    - Load-use and branch effects are suppressed. The frozen EX stage re-presents them after release.
- **loaduse:**
  - Condition: resultsrce_i==2'b01, rde_i≠0, and rde_i equals rs1d_i or rs2d_i.
  - Response: stallf_o = stalld_o = 1 and flushe_o = 1.
- **pcsrce_i:**
  - Response: flushd_o = flushe_o = 1.
  - A simultaneous loaduse still asserts stallf_o/stalld_o, but flushd_o wins on IF/ID.
- **Default (no memstall, loaduse or branch):** all stall and flush outputs are 0 and enablem_o = 1.
- **ERR:**
  - stallf_o = stalld_o = stalle_o = 1.
  - enablem_o = 0.
  - flushw_o = 1.
  - memerr_o = 1 and stays set.
- **Forwarding (forwardae_o shown; forwardbe_o is the same using rs2e_i):**
  - 10 if regwritem_i=1, rdm_i≠0 and rdm_i==rs1e_i.
  - Otherwise 01 if regwritew_i=1, rdw_i≠0 and rdw_i==rs1e_i.
  - Otherwise 00.
  - MEM has priority over WB. Forwarding is active in every state.
- **stallcnt_o:** increments on each clock edge where stallf_o=1, saturates at all-ones, never wraps.

## Timing

- Stall, flush, enable and forward outputs are combinational from the inputs and the current state, with zero latency.
- State, waitcnt, memerr_o and stallcnt_o are registered.
- Reset asserted, at any time including mid-WAIT:
  - state = RUN, waitcnt = 0, memerr_o = 0, stallcnt_o = 0.
  - While reset_ni = 0, the combinational outputs are forced: flushd_o = flushe_o = flushw_o = 1, stalls = 0, enablem_o = 0, forwards = 00.
- On the first cycle of a memory stall the outputs assert immediately, in RUN. The state reads WAIT from the next cycle.
- A single-cycle wait (ready arrives on the second cycle) costs exactly 1 stall cycle.
- Timeout: with ready held low, ERR is entered MEM_TIMEOUT+1 cycles after the request first appears. memerr_o rises on that same edge.
- Ready arriving in the same cycle the timeout is reached counts as completion: the controller returns to RUN, not ERR.

## Test plan

- **Load-use:**
  - Stimulus: resultsrce_i=01, rde_i=5, rs1d_i=5.
  - Required: stallf_o = stalld_o = flushe_o = 1 and stallcnt_o +1.
  - Stimulus: rde_i=0 with rs1d_i=0.
  - Required: no stall.
- **Branch flush:**
  - Stimulus: pcsrce_i=1, with loaduse asserted in the same cycle.
  - Required: flushd_o = flushe_o = 1 and stallf_o = 1.
- **Forwarding:**
  - Stimulus: rdm_i = rdw_i = rs1e_i = 7, both writes on.
  - Required: forwardae_o = 10.
  - Stimulus: regwritem_i=0.
  - Required: 01.
  - Stimulus: register 0.
  - Required: 00.
- **Memory wait:**
  - Stimulus: memreqm_i=1 with ready low for 3 cycles.
  - Required: stalls = 1, enablem_o = 0, flushw_o = 1 for 3 cycles; back to RUN; stallcnt_o = 3; a concurrent pcsrce_i flush is suppressed until release.
- **Timeout:**
  - Stimulus: MEM_TIMEOUT=4, ready held low.
  - Required: memerr_o rises on the 5th edge, outputs frozen; ready arriving later has no effect; only reset_ni low clears the error.
- **Async reset mid-WAIT:**
  - Stimulus: reset_ni low between clock edges.
  - Required: all flushes = 1 and memerr_o / stallcnt_o / state clear immediately without waiting for a clock edge.
  - Stimulus: release reset.
  - Required: operation resumes in RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Central pipeline controller for the five-stage RISC-V core.
//             Generates stall / flush / enable controls for every pipeline
//             register, the EX-stage forwarding selects, a data-memory wait
//             state machine with timeout watchdog and a stall-cycle counter.
//  Ports    : clk_i, reset_ni (async, active-low)
//             rs1d_i/rs2d_i         ID source registers
//             rs1e_i/rs2e_i/rde_i   EX source / destination registers
//             resultsrce_i          EX result source (2'b01 = load)
//             pcsrce_i              taken branch / jump resolved in EX
//             rdm_i/regwritem_i     MEM destination and write enable
//             rdw_i/regwritew_i     WB destination and write enable
//             memreqm_i/memreadym_i data-memory request / completion
//             stall*_o, flush*_o, enablem_o   pipeline register controls
//             forwardae_o/forwardbe_o         EX operand selects
//             memerr_o              sticky memory timeout flag
//             stallcnt_o            saturating count of PC-stall cycles
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [4:0]       rs1d_i,
    input  logic [4:0]       rs2d_i,
    input  logic [4:0]       rs1e_i,
    input  logic [4:0]       rs2e_i,
    input  logic [4:0]       rde_i,
    input  logic [1:0]       resultsrce_i,
    input  logic             pcsrce_i,
    input  logic [4:0]       rdm_i,
    input  logic             regwritem_i,
    input  logic [4:0]       rdw_i,
    input  logic             regwritew_i,
    input  logic             memreqm_i,
    input  logic             memreadym_i,
    output logic             stallf_o,
    output logic             stalld_o,
    output logic             stalle_o,
    output logic             flushd_o,
    output logic             flushe_o,
    output logic             flushw_o,
    output logic             enablem_o,
    output logic [1:0]       forwardae_o,
    output logic [1:0]       forwardbe_o,
    output logic             memerr_o,
    output logic [CNT_W-1:0] stallcnt_o
);

    localparam int             WCW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] C_TIMEOUT = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_waitcnt;
    logic [WCW-1:0]   w_waitcnt_nxt;
    logic [CNT_W-1:0] r_stallcnt;
    logic             w_memstall;
    logic             w_loaduse;

    // MEM result has priority over WB result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wm,
        input logic [4:0] rdm,
        input logic       ww,
        input logic [4:0] rdw
    );
        if (wm && (rdm != 5'd0) && (rdm == rs))
            return 2'b10;
        else if (ww && (rdw != 5'd0) && (rdw == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_memstall = (r_state != S_ERR) & memreqm_i & ~memreadym_i;
    assign w_loaduse  = (resultsrce_i == 2'b01) && (rde_i != 5'd0) &&
                        ((rde_i == rs1d_i) || (rde_i == rs2d_i));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= S_RUN;
            r_waitcnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_waitcnt <= w_waitcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. waitcnt equals the number of cycles the current
    // request has been outstanding, so the watchdog fires on the edge that
    // would make it MEM_TIMEOUT+1. Ready is checked first so a completion
    // in the timeout cycle still counts.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_waitcnt_nxt = r_waitcnt;
        case (r_state)
            S_RUN: begin
                if (w_memstall) begin
                    w_state_nxt   = S_WAIT;
                    w_waitcnt_nxt = WCW'(1);
                end
            end
            S_WAIT: begin
                if (memreadym_i) begin
                    w_state_nxt   = S_RUN;
                    w_waitcnt_nxt = '0;
                end else if (r_waitcnt == C_TIMEOUT) begin
                    w_state_nxt   = S_ERR;
                end else begin
                    w_waitcnt_nxt = r_waitcnt + WCW'(1);
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt   = S_RUN;
                w_waitcnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        stallf_o    = 1'b0;
        stalld_o    = 1'b0;
        stalle_o    = 1'b0;
        flushd_o    = 1'b0;
        flushe_o    = 1'b0;
        flushw_o    = 1'b0;
        enablem_o   = 1'b1;
        forwardae_o = fwd_sel(rs1e_i, regwritem_i, rdm_i, regwritew_i, rdw_i);
        forwardbe_o = fwd_sel(rs2e_i, regwritem_i, rdm_i, regwritew_i, rdw_i);

        if (!reset_ni) begin
            // Hold the whole pipeline as bubbles while in reset.
            flushd_o    = 1'b1;
            flushe_o    = 1'b1;
            flushw_o    = 1'b1;
            enablem_o   = 1'b0;
            forwardae_o = 2'b00;
            forwardbe_o = 2'b00;
        end else if ((r_state == S_ERR) || w_memstall) begin
            // Freeze everything up to EX/MEM and feed bubbles into WB. The
            // frozen EX stage re-presents any branch / load-use afterwards.
            stallf_o  = 1'b1;
            stalld_o  = 1'b1;
            stalle_o  = 1'b1;
            flushw_o  = 1'b1;
            enablem_o = 1'b0;
        end else begin
            if (w_loaduse) begin
                stallf_o = 1'b1;
                stalld_o = 1'b1;
                flushe_o = 1'b1;
            end
            if (pcsrce_i) begin
                flushd_o = 1'b1;
                flushe_o = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            r_stallcnt <= '0;
        else if (stallf_o && (r_stallcnt != {CNT_W{1'b1}}))
            r_stallcnt <= r_stallcnt + CNT_W'(1);
    end

    assign stallcnt_o = r_stallcnt;
    assign memerr_o   = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl: directed vector table,
//             hand-written multi-cycle sequences and randomized stimulus
//             compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic [4:0] rs1d;
        logic [4:0] rs2d;
        logic [4:0] rs1e;
        logic [4:0] rs2e;
        logic [4:0] rde;
        logic [1:0] rsrc;
        logic       pcsrc;
        logic [4:0] rdm;
        logic       wm;
        logic [4:0] rdw;
        logic       ww;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic [10:0] exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [4:0]  rs1d_i, rs2d_i, rs1e_i, rs2e_i, rde_i, rdm_i, rdw_i;
    logic [1:0]  resultsrce_i;
    logic        pcsrce_i, regwritem_i, regwritew_i, memreqm_i, memreadym_i;

    logic        stallf_o, stalld_o, stalle_o, flushd_o, flushe_o, flushw_o, enablem_o;
    logic [1:0]  forwardae_o, forwardbe_o;
    logic        memerr_o;
    logic [31:0] stallcnt_o;

    logic        s_stallf, s_stalld, s_stalle, s_flushd, s_flushe, s_flushw, s_enablem;
    logic [1:0]  s_fa, s_fb;
    logic        s_memerr;
    logic [2:0]  s_stallcnt;

    logic [10:0] act, sact;
    assign act  = {stallf_o, stalld_o, stalle_o, flushd_o, flushe_o, flushw_o,
                   enablem_o, forwardae_o, forwardbe_o};
    assign sact = {s_stallf, s_stalld, s_stalle, s_flushd, s_flushe, s_flushw,
                   s_enablem, s_fa, s_fb};

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) u_dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .rs1d_i(rs1d_i), .rs2d_i(rs2d_i), .rs1e_i(rs1e_i), .rs2e_i(rs2e_i),
        .rde_i(rde_i), .resultsrce_i(resultsrce_i), .pcsrce_i(pcsrce_i),
        .rdm_i(rdm_i), .regwritem_i(regwritem_i), .rdw_i(rdw_i),
        .regwritew_i(regwritew_i), .memreqm_i(memreqm_i), .memreadym_i(memreadym_i),
        .stallf_o(stallf_o), .stalld_o(stalld_o), .stalle_o(stalle_o),
        .flushd_o(flushd_o), .flushe_o(flushe_o), .flushw_o(flushw_o),
        .enablem_o(enablem_o), .forwardae_o(forwardae_o), .forwardbe_o(forwardbe_o),
        .memerr_o(memerr_o), .stallcnt_o(stallcnt_o)
    );

    // Narrow-counter instance to exercise saturation.
    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(3)) u_sat (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .rs1d_i(rs1d_i), .rs2d_i(rs2d_i), .rs1e_i(rs1e_i), .rs2e_i(rs2e_i),
        .rde_i(rde_i), .resultsrce_i(resultsrce_i), .pcsrce_i(pcsrce_i),
        .rdm_i(rdm_i), .regwritem_i(regwritem_i), .rdw_i(rdw_i),
        .regwritew_i(regwritew_i), .memreqm_i(memreqm_i), .memreadym_i(memreadym_i),
        .stallf_o(s_stallf), .stalld_o(s_stalld), .stalle_o(s_stalle),
        .flushd_o(s_flushd), .flushe_o(s_flushe), .flushw_o(s_flushw),
        .enablem_o(s_enablem), .forwardae_o(s_fa), .forwardbe_o(s_fb),
        .memerr_o(s_memerr), .stallcnt_o(s_stallcnt)
    );

    int     n_vec = 0;
    int     n_bad = 0;

    // Behavioural model: error flag, cycles the current request has been
    // outstanding, and the unbounded count of stall cycles.
    bit     m_err;
    int     m_pend;
    longint m_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic in_t mk(input int rs1d, input int rs2d, input int rs1e,
                               input int rs2e, input int rde, input int rsrc,
                               input int pcsrc, input int rdm, input int wm,
                               input int rdw, input int ww, input int req,
                               input int rdy);
        in_t v;
        v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
        v.rde = 5'(rde); v.rsrc = 2'(rsrc); v.pcsrc = 1'(pcsrc);
        v.rdm = 5'(rdm); v.wm = 1'(wm); v.rdw = 5'(rdw); v.ww = 1'(ww);
        v.req = 1'(req); v.rdy = 1'(rdy);
        return v;
    endfunction

    task automatic apply(input in_t v);
        rs1d_i = v.rs1d; rs2d_i = v.rs2d; rs1e_i = v.rs1e; rs2e_i = v.rs2e;
        rde_i = v.rde; resultsrce_i = v.rsrc; pcsrce_i = v.pcsrc;
        rdm_i = v.rdm; regwritem_i = v.wm; rdw_i = v.rdw; regwritew_i = v.ww;
        memreqm_i = v.req; memreadym_i = v.rdy;
    endtask

    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (regwritem_i && rdm_i != 0 && rdm_i == rs) return 2'b10;
        if (regwritew_i && rdw_i != 0 && rdw_i == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected combinational outputs from the controller's rules.
    function automatic logic [10:0] model_out();
        logic lu, br;
        if (!reset_ni)
            return 11'b0001110_00_00;
        if (m_err || (memreqm_i && !memreadym_i))
            return {7'b1110010, fsel(rs1e_i), fsel(rs2e_i)};
        lu = (resultsrce_i == 2'b01) && (rde_i != 0) &&
             (rde_i == rs1d_i || rde_i == rs2d_i);
        br = pcsrce_i;
        return {lu, lu, 1'b0, br, lu | br, 1'b0, 1'b1, fsel(rs1e_i), fsel(rs2e_i)};
    endfunction

    task automatic model_edge();
        logic [10:0] o;
        o = model_out();
        if (o[10] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (!m_err) begin
            if (memreqm_i && !memreadym_i) begin
                m_pend++;
                if (m_pend == TO + 1) m_err = 1'b1;
            end else begin
                m_pend = 0;
            end
        end
    endtask

    task automatic step(input string tag);
        logic [10:0] e;
        #1;
        e = model_out();
        chk({tag, " outputs"}, 32'(act), 32'(e));
        chk({tag, " outputs_sat"}, 32'(sact), 32'(e));
        model_edge();
        @(posedge clk_i);
        #1;
        chk({tag, " memerr"}, 32'(memerr_o), 32'(m_err));
        chk({tag, " stallcnt"}, stallcnt_o, m_cnt[31:0]);
        chk({tag, " stallcnt_sat"}, 32'(s_stallcnt), (m_cnt > 7) ? 32'd7 : m_cnt[31:0]);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        chk("reset outputs", 32'(act), 32'(11'b0001110_00_00));
        chk("reset memerr", 32'(memerr_o), 32'd0);
        chk("reset stallcnt", stallcnt_o, 32'd0);
        m_err = 1'b0; m_pend = 0; m_cnt = 0;
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
    endtask

    vec_t tbl [11];
    in_t  v;

    initial begin
        tbl[0]  = '{mk(5,0,0,0,5,1,0,0,0,0,0,0,0),   11'b1100101_00_00};
        tbl[1]  = '{mk(0,0,0,0,0,1,0,0,0,0,0,0,0),   11'b0000001_00_00};
        tbl[2]  = '{mk(3,9,0,0,9,1,0,0,0,0,0,0,0),   11'b1100101_00_00};
        tbl[3]  = '{mk(5,0,0,0,5,0,0,0,0,0,0,0,0),   11'b0000001_00_00};
        tbl[4]  = '{mk(0,0,0,0,0,0,1,0,0,0,0,0,0),   11'b0001101_00_00};
        tbl[5]  = '{mk(5,0,0,0,5,1,1,0,0,0,0,0,0),   11'b1101101_00_00};
        tbl[6]  = '{mk(0,0,7,0,0,0,0,7,1,7,1,0,0),   11'b0000001_10_00};
        tbl[7]  = '{mk(0,0,7,0,0,0,0,7,0,7,1,0,0),   11'b0000001_01_00};
        tbl[8]  = '{mk(0,0,0,0,0,0,0,0,1,0,1,0,0),   11'b0000001_00_00};
        tbl[9]  = '{mk(0,0,3,12,0,0,0,3,1,12,1,0,0), 11'b0000001_10_01};
        tbl[10] = '{mk(0,0,0,0,0,0,0,0,0,0,0,1,1),   11'b0000001_00_00};

        reset_ni = 1'b1;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        do_reset();

        // ---------------- directed single-cycle vectors ----------------
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].in);
            #1;
            chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
            step($sformatf("vec%0d", i));
        end

        // ---------------- 3-cycle memory wait with concurrent branch ----
        do_reset();
        v = mk(0,0,0,0,0,0,1,0,0,0,0,1,0);
        for (int k = 0; k < 3; k++) begin
            apply(v);
            #1;
            chk("memwait frozen", 32'(act), 32'(11'b1110010_00_00));
            step("memwait");
        end
        chk("memwait stallcnt", stallcnt_o, 32'd3);
        v.rdy = 1'b1;
        apply(v);
        #1;
        chk("memwait release flush", 32'(act), 32'(11'b0001101_00_00));
        step("release");
        chk("release stallcnt", stallcnt_o, 32'd3);
        v.pcsrc = 1'b0; v.rdy = 1'b0;
        apply(v); step("single wait");
        v.rdy = 1'b1;
        apply(v); step("single done");
        chk("single wait cost", stallcnt_o, 32'd4);

        // ---------------- timeout -> ERR ---------------------------------
        do_reset();
        v = mk(0,0,0,0,0,0,0,0,0,0,0,1,0);
        for (int k = 1; k <= TO + 1; k++) begin
            apply(v);
            step("timeout");
            chk($sformatf("memerr after edge %0d", k), 32'(memerr_o), (k == TO + 1) ? 32'd1 : 32'd0);
        end
        v = mk(0,0,0,0,0,0,1,0,0,0,0,0,1);
        apply(v);
        #1;
        chk("err frozen", 32'(act), 32'(11'b1110010_00_00));
        step("err late ready");
        chk("err sticky", 32'(memerr_o), 32'd1);
        do_reset();

        // ---------------- ready in the timeout cycle --------------------
        v = mk(0,0,0,0,0,0,0,0,0,0,0,1,0);
        for (int k = 0; k < TO; k++) begin
            apply(v);
            step("edge wait");
        end
        v.rdy = 1'b1;
        apply(v);
        step("edge ready");
        chk("ready at timeout memerr", 32'(memerr_o), 32'd0);
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        chk("ready at timeout run", 32'(act), 32'(11'b0000001_00_00));
        step("after edge ready");

        // ---------------- asynchronous reset mid-WAIT -------------------
        v = mk(0,0,7,0,0,0,0,7,1,0,0,1,0);
        apply(v); step("pre-reset");
        apply(v); step("pre-reset");
        #2;
        reset_ni = 1'b0;
        #1;
        chk("async reset outputs", 32'(act), 32'(11'b0001110_00_00));
        chk("async reset stallcnt", stallcnt_o, 32'd0);
        chk("async reset memerr", 32'(memerr_o), 32'd0);
        m_err = 1'b0; m_pend = 0; m_cnt = 0;
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        chk("resume run", 32'(act), 32'(11'b0000001_00_00));
        step("resume");

        // ---------------- randomized stimulus vs model ------------------
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 49) do_reset();
            v.rs1d  = 5'($urandom_range(0, 3));
            v.rs2d  = 5'($urandom_range(0, 3));
            v.rs1e  = 5'($urandom_range(0, 3));
            v.rs2e  = 5'($urandom_range(0, 3));
            v.rde   = 5'($urandom_range(0, 3));
            v.rsrc  = 2'($urandom_range(0, 3));
            v.pcsrc = ($urandom_range(0, 3) == 0);
            v.rdm   = 5'($urandom_range(0, 3));
            v.wm    = 1'($urandom_range(0, 1));
            v.rdw   = 5'($urandom_range(0, 3));
            v.ww    = 1'($urandom_range(0, 1));
            // An outstanding request stays asserted until it completes.
            v.req   = (m_pend > 0 && !m_err) ? 1'b1 : ($urandom_range(0, 2) == 0);
            v.rdy   = ($urandom_range(0, 3) == 0);
            apply(v);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
